// File: rtl/mlp_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mlp_layer_sequencer
// Description : Steps one dense-layer slice through the 8-lane Multiplier:
//               fetches x[k] and weight rows, then activates and writes outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_layer_sequencer #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] n_in,
  input  logic [AW-1:0] x_base,
  input  logic [AW-1:0] w_base,
  input  logic [AW-1:0] y_addr_in,
  input  logic [7:0]    shift_in,
  output logic [AW-1:0] x_addr,
  input  logic [7:0]    x_rd_data,
  output logic [AW-1:0] w_addr,
  input  logic [63:0]   w_rd_data,
  output logic [2:0]    step,
  output logic [7:0]    shift,
  output logic [7:0]    A,
  output logic [63:0]   B,
  input  logic [63:0]   Y,
  input  logic          ovf_in,
  output logic          y_we,
  output logic [AW-1:0] y_addr,
  output logic [63:0]   y_data,
  output logic          busy,
  output logic          done,
  output logic          layer_ovf
);

  localparam logic [2:0]    c_step_wait = 3'd0;
  localparam logic [2:0]    c_step_mult = 3'd1;
  localparam logic [2:0]    c_step_acc  = 3'd2;
  localparam logic [2:0]    c_step_act  = 3'd3;
  localparam logic [2:0]    c_step_mwa  = 3'd4;
  localparam logic [AW-1:0] c_one       = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_MUL, S_ACC, S_ACT, S_DRAIN, S_CAPTURE, S_DONE
  } state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_k, r_n_in, r_x_base, r_w_base, r_x_addr, r_w_addr, r_y_addr;
  logic [7:0]    r_shift, r_a;
  logic [63:0]   r_b;
  logic          r_layer_ovf;
  logic          w_accept, w_last;

  assign w_accept = (r_state == S_IDLE) && start && (n_in != '0);
  assign w_last   = (r_k == (r_n_in - c_one));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_n_in      <= '0;
      r_x_base    <= '0;
      r_w_base    <= '0;
      r_x_addr    <= '0;
      r_w_addr    <= '0;
      r_y_addr    <= '0;
      r_shift     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_layer_ovf <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_n_in      <= n_in;
            r_x_base    <= x_base;
            r_w_base    <= w_base;
            r_y_addr    <= y_addr_in;
            r_shift     <= shift_in;
            r_k         <= '0;
            r_layer_ovf <= 1'b0;
            // Element 0 address is presented during FETCH
            r_x_addr    <= x_base;
            r_w_addr    <= w_base;
          end
        end
        S_MUL: begin
          r_a <= x_rd_data;
          r_b <= w_rd_data;
          // Next element's address is on the bus during ACC so its data lands in the next MUL
          if (!w_last) begin
            r_x_addr <= r_x_base + r_k + c_one;
            r_w_addr <= r_w_base + r_k + c_one;
          end
        end
        S_ACC: begin
          if (!w_last) r_k <= r_k + c_one;
        end
        S_CAPTURE: r_layer_ovf <= ovf_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    step   = c_step_wait;
    y_we   = 1'b0;
    y_data = '0;
    done   = 1'b0;
    busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_next = S_FETCH;
      end
      S_FETCH: w_next = S_MUL;
      S_MUL: begin
        step   = (r_k == '0) ? c_step_mwa : c_step_mult;
        w_next = S_ACC;
      end
      S_ACC: begin
        step   = c_step_acc;
        w_next = w_last ? S_ACT : S_MUL;
      end
      S_ACT: begin
        step   = c_step_act;
        w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_CAPTURE;
      S_CAPTURE: begin
        y_we   = 1'b1;
        y_data = Y;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        busy   = 1'b0;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign x_addr    = r_x_addr;
  assign w_addr    = r_w_addr;
  assign y_addr    = r_y_addr;
  assign shift     = r_shift;
  assign A         = r_a;
  assign B         = r_b;
  assign layer_ovf = r_layer_ovf;

endmodule
`default_nettype wire
